// File: rtl/shift_ctrl_pkg.sv
// Shared types for shift_ctrl: op encoding, FSM states, ID width and the
// barrel-shift helper. The PASS2 state exists only when SHIFT_ROTATE_EN is defined.
package shift_ctrl_pkg;

    localparam int unsigned ID_W = 1;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

`ifdef SHIFT_ROTATE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_RESP  = 2'd3
    } state_e;
`endif

    // One 32-bit barrel shifter: left, logical right or arithmetic right.
    function automatic logic [31:0] barrel_shift(input logic [31:0] d,
                                                 input logic [4:0]  amt,
                                                 input logic        right,
                                                 input logic        arith);
        logic [31:0] r;
        if (right && arith)
            r = $signed(d) >>> amt;
        else if (right)
            r = d >> amt;
        else
            r = d << amt;
        return r;
    endfunction

endpackage

// File: rtl/shift_rr_arb2.sv
// Two-way arbiter: one-hot grant from two valids, round-robin on last_grant,
// or requester 0 always winning a tie when FIXED_PRIO != 0.
module shift_rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_grant;

    // Grant selection; a tie goes to the requester that did not win last.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (FIXED_PRIO != 0)
                    grant = 2'b01;
                else
                    grant = last_grant ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of each transfer; reset to 1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: shares one 32-bit barrel shifter between two requesters.
// Optional feature macro: SHIFT_ROTATE_EN (ROR as two shifter passes);
// without it ROR bypasses the shifter and reports rsp_err.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [31:0]     req_d0,
    input  logic [4:0]      req_sa0,
    input  logic [1:0]      req_op0,
    input  logic [31:0]     req_d1,
    input  logic [4:0]      req_sa1,
    input  logic [1:0]      req_op1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output logic [31:0]     rsp_data,
    output logic            rsp_err
);

    state_e          state_q, state_d;
    logic [1:0]      grant;
    logic            take;

    logic [31:0]     d_q;
    logic [4:0]      sa_q;
    shift_op_e       op_q;
    logic [ID_W-1:0] id_q;

    logic [31:0]     sh_out;
    logic [4:0]      sh_amt;
    logic            sh_right;
    logic            sh_arith;

`ifdef SHIFT_ROTATE_EN
    logic [31:0]     partial_q;
`endif

    shift_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .take  (take),
        .grant (grant)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    assign take      = |(req_valid & req_ready);

    // Single shifter instance; its controls are selected by the current pass.
    always_comb begin
        sh_amt   = sa_q;
        sh_right = (op_q != OP_SLL);
        sh_arith = (op_q == OP_SRA);
`ifdef SHIFT_ROTATE_EN
        // Second ROR pass: left by (32 - sa) mod 32; sa=0 wraps to 0 so d|d = d.
        if (state_q == ST_PASS2) begin
            sh_amt   = 5'd0 - sa_q;
            sh_right = 1'b0;
            sh_arith = 1'b0;
        end
`endif
        sh_out = barrel_shift(d_q, sh_amt, sh_right, sh_arith);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (take) state_d = ST_PASS1;
`ifdef SHIFT_ROTATE_EN
            ST_PASS1: state_d = (op_q == OP_ROR) ? ST_PASS2 : ST_RESP;
            ST_PASS2: state_d = ST_RESP;
`else
            ST_PASS1: state_d = ST_RESP;
`endif
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the granted requester's operands on transfer.
    always_ff @(posedge clk) begin
        if (take) begin
            if (grant[1]) begin
                d_q  <= req_d1;
                sa_q <= req_sa1;
                op_q <= shift_op_e'(req_op1);
                id_q <= 1'b1;
            end else begin
                d_q  <= req_d0;
                sa_q <= req_sa0;
                op_q <= shift_op_e'(req_op0);
                id_q <= 1'b0;
            end
        end
    end

    // Result registers: captured at the end of the last pass, held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            partial_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_PASS1: begin
`ifdef SHIFT_ROTATE_EN
                    if (op_q == OP_ROR) begin
                        partial_q <= sh_out;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_data  <= sh_out;
                        rsp_err   <= 1'b0;
                    end
`else
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_data  <= (op_q == OP_ROR) ? d_q : sh_out;
                    rsp_err   <= (op_q == OP_ROR);
`endif
                end
`ifdef SHIFT_ROTATE_EN
                ST_PASS2: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_data  <= partial_q | sh_out;
                    rsp_err   <= 1'b0;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
